// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_parser
//  Purpose  : Turns ASCII "W <addr> <data>" / "R <addr>" lines from the UART
//             receive path into single memory-access requests.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_data,
    output logic              err_pulse,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SP1   = 3'd1;
    localparam logic [2:0] c_ST_ADDR  = 3'd2;
    localparam logic [2:0] c_ST_SP2   = 3'd3;
    localparam logic [2:0] c_ST_DATA  = 3'd4;
    localparam logic [2:0] c_ST_ISSUE = 3'd5;
    localparam logic [2:0] c_ST_SKIP  = 3'd6;

    localparam logic [1:0] c_ERR_CHAR = 2'd1;
    localparam logic [1:0] c_ERR_LEN  = 2'd2;
    localparam logic [1:0] c_ERR_MISS = 2'd3;
    localparam logic [3:0] c_MAX_DIG  = 4'd8;

    logic [2:0]        r_state;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr_acc;
    logic [DATA_W-1:0] r_data_acc;
    logic [3:0]        r_cnt;
    logic              r_err_pulse;
    logic [1:0]        r_err_code;

    logic              w_accept;
    logic              w_is_hex;
    logic              w_is_term;
    logic              w_is_space;
    logic              w_is_wr;
    logic              w_is_rd;
    logic [3:0]        w_nib;

    always_comb begin
        w_is_hex = 1'b1;
        w_nib    = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            w_nib = 4'(rx_data - 8'h30);
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            w_nib = 4'(rx_data - 8'h37);
        end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            w_nib = 4'(rx_data - 8'h57);
        end else begin
            w_is_hex = 1'b0;
        end
    end

    assign w_is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign w_is_space = (rx_data == 8'h20);
    assign w_is_wr    = (rx_data == 8'h57) || (rx_data == 8'h77);
    assign w_is_rd    = (rx_data == 8'h52) || (rx_data == 8'h72);

    // Nothing is consumed while a request waits for the downstream handshake.
    assign rx_ready  = (r_state != c_ST_ISSUE);
    assign w_accept  = rx_valid & rx_ready;
    assign cmd_valid = (r_state == c_ST_ISSUE);
    assign busy      = (r_state != c_ST_IDLE);
    assign cmd_write = r_write;
    assign cmd_addr  = r_addr_acc;
    assign cmd_data  = r_data_acc;
    assign err_pulse = r_err_pulse;
    assign err_code  = r_err_code;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_ST_IDLE;
            r_write     <= 1'b0;
            r_addr_acc  <= '0;
            r_data_acc  <= '0;
            r_cnt       <= 4'd0;
            r_err_pulse <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_err_pulse <= 1'b0;
            if (r_state == c_ST_ISSUE) begin
                if (cmd_ready) begin
                    r_state <= c_ST_IDLE;
                end
            end else if (w_accept) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_is_wr || w_is_rd) begin
                            r_state    <= c_ST_SP1;
                            r_write    <= w_is_wr;
                            r_addr_acc <= '0;
                            r_data_acc <= '0;
                            r_cnt      <= 4'd0;
                        end else if (!w_is_term && !w_is_space) begin
                            r_state     <= c_ST_SKIP;
                            r_err_pulse <= 1'b1;
                            r_err_code  <= c_ERR_CHAR;
                        end
                    end
                    c_ST_SP1: begin
                        if (w_is_hex) begin
                            r_state    <= c_ST_ADDR;
                            r_addr_acc <= ADDR_W'(w_nib);
                            r_cnt      <= 4'd1;
                        end else if (w_is_term) begin
                            r_state     <= c_ST_IDLE;
                            r_err_pulse <= 1'b1;
                            r_err_code  <= c_ERR_MISS;
                        end else if (!w_is_space) begin
                            r_state     <= c_ST_SKIP;
                            r_err_pulse <= 1'b1;
                            r_err_code  <= c_ERR_CHAR;
                        end
                    end
                    c_ST_ADDR: begin
                        if (w_is_hex && r_cnt == c_MAX_DIG) begin
                            r_state     <= c_ST_SKIP;
                            r_err_pulse <= 1'b1;
                            r_err_code  <= c_ERR_LEN;
                        end else if (w_is_hex) begin
                            r_addr_acc <= ADDR_W'({r_addr_acc, w_nib});
                            r_cnt      <= r_cnt + 4'd1;
                        end else if (w_is_space) begin
                            r_state <= c_ST_SP2;
                        end else if (w_is_term && !r_write) begin
                            r_state <= c_ST_ISSUE;
                        end else begin
                            r_state     <= w_is_term ? c_ST_IDLE : c_ST_SKIP;
                            r_err_pulse <= 1'b1;
                            r_err_code  <= w_is_term ? c_ERR_MISS : c_ERR_CHAR;
                        end
                    end
                    c_ST_SP2: begin
                        if (w_is_space) begin
                            r_state <= c_ST_SP2;
                        end else if (w_is_term && !r_write) begin
                            r_state <= c_ST_ISSUE;
                        end else if (w_is_term) begin
                            r_state     <= c_ST_IDLE;
                            r_err_pulse <= 1'b1;
                            r_err_code  <= c_ERR_MISS;
                        end else if (w_is_hex && r_write) begin
                            r_state    <= c_ST_DATA;
                            r_data_acc <= DATA_W'(w_nib);
                            r_cnt      <= 4'd1;
                        end else begin
                            r_state     <= c_ST_SKIP;
                            r_err_pulse <= 1'b1;
                            r_err_code  <= c_ERR_CHAR;
                        end
                    end
                    c_ST_DATA: begin
                        if (w_is_hex && r_cnt == c_MAX_DIG) begin
                            r_state     <= c_ST_SKIP;
                            r_err_pulse <= 1'b1;
                            r_err_code  <= c_ERR_LEN;
                        end else if (w_is_hex) begin
                            r_data_acc <= DATA_W'({r_data_acc, w_nib});
                            r_cnt      <= r_cnt + 4'd1;
                        end else if (w_is_term) begin
                            r_state <= c_ST_ISSUE;
                        end else begin
                            r_state     <= c_ST_SKIP;
                            r_err_pulse <= 1'b1;
                            r_err_code  <= c_ERR_CHAR;
                        end
                    end
                    c_ST_SKIP: begin
                        if (w_is_term) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_parser
//  Purpose  : Directed and random command lines checked against a line-level
//             reference parser.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [27:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  exp_code = 2'd0;

    uart_cmd_parser #(.ADDR_W(28), .DATA_W(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_term(input logic [7:0] c);
        return (c == 8'h0D) || (c == 8'h0A);
    endfunction

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Field-level view of one line: where (if anywhere) it first goes wrong,
    // and what request it yields otherwise.
    function automatic void model(input string s, output int epos, output int ecode,
                                  output int tpos, output bit req, output bit wr,
                                  output logic [31:0] a, output logic [31:0] d);
        int    i;
        int    st;
        string f;
        epos = -1; ecode = 0; req = 0; wr = 0; a = '0; d = '0; i = 0; tpos = 0;
        while (!is_term(s[tpos])) tpos++;
        while (s[i] == 8'h20) i++;
        if (is_term(s[i])) return;
        if (!(s[i] inside {8'h57, 8'h77, 8'h52, 8'h72})) begin
            epos = i; ecode = 1; return;
        end
        wr = (s[i] == 8'h57) || (s[i] == 8'h77);
        i++;
        while (s[i] == 8'h20) i++;
        if (!is_hex(s[i])) begin
            epos = i; ecode = is_term(s[i]) ? 3 : 1; return;
        end
        st = i;
        while (is_hex(s[i])) begin
            if (i - st == 8) begin epos = i; ecode = 2; return; end
            i++;
        end
        f = s.substr(st, i - 1);
        a = f.atohex();
        if (s[i] != 8'h20 && !is_term(s[i])) begin epos = i; ecode = 1; return; end
        while (s[i] == 8'h20) i++;
        if (is_term(s[i])) begin
            if (wr) begin epos = i; ecode = 3; end
            else req = 1;
            return;
        end
        if (!wr || !is_hex(s[i])) begin epos = i; ecode = 1; return; end
        st = i;
        while (is_hex(s[i])) begin
            if (i - st == 8) begin epos = i; ecode = 2; return; end
            i++;
        end
        f = s.substr(st, i - 1);
        d = f.atohex();
        if (is_term(s[i])) req = 1;
        else begin epos = i; ecode = 1; end
    endfunction

    function automatic string gen_line();
        string hs;
        string lt;
        string jk;
        string s;
        int    idx;
        bit    wr;
        int    nd;
        hs = "0123456789abcdefABCDEF";
        lt = "WwRr";
        jk = "gZ-!.";
        s  = "";
        if ($urandom_range(0, 7) == 0) s = " ";
        idx = $urandom_range(0, 3);
        wr  = (idx < 2);
        s   = $sformatf("%s%c", s, lt[idx]);
        repeat ($urandom_range(0, 2)) s = {s, " "};
        nd = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(1, 8);
        if ($urandom_range(0, 12) == 0) nd = 0;
        repeat (nd) s = $sformatf("%s%c", s, hs[$urandom_range(0, 21)]);
        if (wr && $urandom_range(0, 9) != 0) begin
            repeat ($urandom_range(1, 2)) s = {s, " "};
            nd = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(1, 8);
            repeat (nd) s = $sformatf("%s%c", s, hs[$urandom_range(0, 21)]);
        end else if (!wr && $urandom_range(0, 3) == 0) begin
            s = {s, " "};
        end
        if ($urandom_range(0, 5) == 0)
            s.putc($urandom_range(0, s.len() - 1), jk[$urandom_range(0, 4)]);
        s = $sformatf("%s%c", s, ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
        if ($urandom_range(0, 2) == 0) s = {s, "\n"};
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input int stall);
        int k;
        k = (stall < 0) ? $urandom_range(0, 5) : stall;
        chk("cmd_write", cmd_write, wr);
        chk("cmd_addr", cmd_addr, a[27:0]);
        chk("cmd_data", cmd_data, d);
        chk("busy_issue", busy, 1);
        chk("rx_ready_issue", rx_ready, 0);
        cmd_ready = 1'b0;
        rx_data   = 8'h0A;
        rx_valid  = 1'b1;
        repeat (k) begin
            @(posedge clk);
            #1;
            chk("stall_valid", cmd_valid, 1);
            chk("stall_rx_ready", rx_ready, 0);
            chk("stall_addr", cmd_addr, a[27:0]);
            chk("stall_data", cmd_data, d);
            chk("stall_write", cmd_write, wr);
        end
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        rx_valid  = 1'b0;
        chk("post_hs_valid", cmd_valid, 0);
        chk("post_hs_rx_ready", rx_ready, 1);
        chk("post_hs_busy", busy, 0);
    endtask

    task automatic run_line(input string s, input int stall);
        int         epos;
        int         ecode;
        int         tpos;
        bit         req;
        bit         wr;
        logic [31:0] a;
        logic [31:0] d;
        model(s, epos, ecode, tpos, req, wr, a, d);
        for (int i = 0; i < s.len(); i++) begin
            chk("rx_ready_line", rx_ready, 1);
            send_byte(s[i]);
            chk("err_pulse", err_pulse, (i == epos));
            if (i == epos) exp_code = 2'(ecode);
            chk("err_code", err_code, exp_code);
            if (i == tpos) begin
                chk("cmd_valid_after_term", cmd_valid, req);
                if (req) issue(wr, a, d, stall);
                else chk("busy_after_line", busy, 0);
            end
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_write", cmd_write, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_ready", rx_ready, 1);
    endtask

    initial begin
        string part;
        rstn      = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
        #3;
        chk_reset_values();
        @(posedge clk);
        #1;
        rstn = 1'b1;

        run_line("W 10 CAFEBABE\015", -1);
        run_line("r 0000abc\015\012", -1);
        run_line("R 123456789\015", -1);
        run_line("R 1\015", -1);
        run_line("X 12\015", -1);
        run_line("W 5\015", -1);
        run_line("W 4 55AA55AA\015", 5);

        for (int n = 0; n < 60; n++) run_line(gen_line(), -1);

        // Reset mid-line must drop the partial command entirely.
        part = "W 12";
        for (int i = 0; i < part.len(); i++) send_byte(part[i]);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_values();
        exp_code = 2'd0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run_line("R 7\015", -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
